// File: rtl/quant_zigzag_buffer_if.sv
// Bus between the quantizer's divider output, the zigzag reorder buffer and its downstream consumer.
// The master side drives the divider entries and out_ready; the slave side is the buffer.
interface quant_zigzag_buffer_if #(
  parameter int coef_width = 12
);
  logic                  in_valid;
  logic [5:0]            in_tag;
  logic [coef_width-1:0] in_coef;
  logic                  out_valid;
  logic                  out_ready;
  logic [coef_width-1:0] out_coef;
  logic [5:0]            out_index;
  logic                  out_last;
  logic                  overflow;

  modport master (
    output in_valid, in_tag, in_coef, out_ready,
    input  out_valid, out_coef, out_index, out_last, overflow
  );

  modport slave (
    input  in_valid, in_tag, in_coef, out_ready,
    output out_valid, out_coef, out_index, out_last, overflow
  );
endinterface

// File: rtl/quant_zigzag_buffer.sv
// Double-banked 8x8 coefficient buffer: gathers raster-tagged divider output in any order
// and streams each completed block in JPEG zigzag order over a valid/ready port.
module quant_zigzag_buffer #(
  parameter int coef_width = 12
) (
  input  logic                 clock,
  input  logic                 reset_n,
  quant_zigzag_buffer_if.slave bus
);

  typedef enum logic [1:0] {
    BANK_EMPTY   = 2'd0,
    BANK_FILLING = 2'd1,
    BANK_FULL    = 2'd2
  } bank_state_t;

  typedef enum logic {
    RD_IDLE   = 1'b0,
    RD_STREAM = 1'b1
  } rd_state_t;

  // Zigzag index k -> raster position row*8+col.
  localparam logic [5:0] ZZ [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  // Both banks share one array; the bank number is the top address bit.
  logic [coef_width-1:0] coef_mem [128];

  logic [1:0]            bank_full;
  logic [1:0]            bank_complete;
  logic [1:0]            wr_sel;
  logic [1:0]            rel_sel;
  logic [63:0]           tag_onehot;

  logic                  wb_q, wb_d;
  logic                  rb_q, rb_d;
  rd_state_t             rd_state_q, rd_state_d;
  logic                  out_valid_q, out_valid_d;
  logic [5:0]            out_index_q, out_index_d;
  logic [coef_width-1:0] out_coef_q, out_coef_d;
  logic                  overflow_q, overflow_d;

  logic                  wr_accept;
  logic                  wr_drop;
  logic                  wr_complete;
  logic                  handshake;
  logic                  last_beat;
  logic                  release_bank;
  logic                  load;
  logic                  load_bank;
  logic [5:0]            load_k;

  assign tag_onehot   = 64'd1 << bus.in_tag;
  assign wr_accept    = bus.in_valid && !bank_full[wb_q];
  assign wr_drop      = bus.in_valid && bank_full[wb_q];
  assign wr_complete  = bank_complete[wb_q];
  assign handshake    = out_valid_q && bus.out_ready;
  assign last_beat    = (out_index_q == 6'd63);
  assign release_bank = handshake && last_beat;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
      bank_state_t state_q, state_d;
      logic [63:0] mask_q, mask_d;

      assign bank_full[gi]     = (state_q == BANK_FULL);
      assign bank_complete[gi] = &(mask_q | tag_onehot);
      assign wr_sel[gi]        = wr_accept && (wb_q == 1'(gi));
      assign rel_sel[gi]       = release_bank && (rb_q == 1'(gi));

      // A bank is never written while FULL and only released while FULL, so the
      // two selects are mutually exclusive for any one bank.
      always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        if (wr_sel[gi]) begin
          mask_d  = mask_q | tag_onehot;
          state_d = bank_complete[gi] ? BANK_FULL : BANK_FILLING;
        end else if (rel_sel[gi]) begin
          mask_d  = '0;
          state_d = BANK_EMPTY;
        end
      end

      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          state_q <= BANK_EMPTY;
          mask_q  <= '0;
        end else begin
          state_q <= state_d;
          mask_q  <= mask_d;
        end
      end
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (wr_accept) begin
      coef_mem[{wb_q, bus.in_tag}] <= bus.in_coef;
    end
  end

  always_comb begin
    wb_d       = wb_q;
    overflow_d = overflow_q | wr_drop;
    if (wr_accept && wr_complete) begin
      wb_d = ~wb_q;
    end
  end

  // Entering STREAM costs one edge; the first beat is loaded on the following edge.
  always_comb begin
    rd_state_d  = rd_state_q;
    rb_d        = rb_q;
    out_valid_d = out_valid_q;
    out_index_d = out_index_q;
    out_coef_d  = out_coef_q;
    load        = 1'b0;
    load_bank   = rb_q;
    load_k      = '0;

    case (rd_state_q)
      RD_IDLE: begin
        if (bank_full[rb_q]) begin
          rd_state_d = RD_STREAM;
        end
      end
      RD_STREAM: begin
        if (!out_valid_q) begin
          load = 1'b1;
        end else if (handshake) begin
          if (!last_beat) begin
            load   = 1'b1;
            load_k = out_index_q + 6'd1;
          end else begin
            rb_d = ~rb_q;
            if (bank_full[~rb_q]) begin
              load      = 1'b1;
              load_bank = ~rb_q;
            end else begin
              rd_state_d  = RD_IDLE;
              out_valid_d = 1'b0;
              out_index_d = '0;
            end
          end
        end
      end
    endcase

    if (load) begin
      out_valid_d = 1'b1;
      out_index_d = load_k;
      out_coef_d  = coef_mem[{load_bank, ZZ[load_k]}];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wb_q        <= 1'b0;
      rb_q        <= 1'b0;
      rd_state_q  <= RD_IDLE;
      out_valid_q <= 1'b0;
      out_index_q <= '0;
      out_coef_q  <= '0;
      overflow_q  <= 1'b0;
    end else begin
      wb_q        <= wb_d;
      rb_q        <= rb_d;
      rd_state_q  <= rd_state_d;
      out_valid_q <= out_valid_d;
      out_index_q <= out_index_d;
      out_coef_q  <= out_coef_d;
      overflow_q  <= overflow_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_index = out_index_q;
  assign bus.out_last  = (out_index_q == 6'd63);
  assign bus.out_coef  = out_coef_q;
  assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_quant_zigzag_buffer.sv
// Bench for quant_zigzag_buffer: a block-level model (completed blocks expanded into a
// zigzag beat queue) checked every cycle, plus directed scenarios with literal expectations.
module tb_quant_zigzag_buffer;
  localparam int CW = 12;

  logic clock = 1'b0;
  logic reset_n = 1'b0;

  quant_zigzag_buffer_if #(.coef_width(CW)) bus ();

  quant_zigzag_buffer #(.coef_width(CW)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  // Model state
  int               zz_m [64];
  logic [CW-1:0]    part [64];
  logic [63:0]      pmask = '0;
  logic [CW-1:0]    exp_q [$];
  int               full_cnt = 0;
  logic             exp_ovf = 1'b0;
  int               beat_pos = 0;
  logic             expect_vld_next = 1'b0;
  int               stall_cnt = 0;
  int               beats_seen = 0;

  task automatic chk(input string name, input int act, input int want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, want, $time);
    end
  endtask

  // Zigzag derived by walking anti-diagonals, alternating direction.
  function automatic void build_zz();
    int k = 0;
    for (int s = 0; s < 15; s++) begin
      int lo = (s > 7) ? s - 7 : 0;
      int hi = (s < 7) ? s : 7;
      if (s % 2 == 0) begin
        for (int r = hi; r >= lo; r--) begin
          zz_m[k] = r * 8 + (s - r);
          k++;
        end
      end else begin
        for (int r = lo; r <= hi; r++) begin
          zz_m[k] = r * 8 + (s - r);
          k++;
        end
      end
    end
  endfunction

  // Inputs change just after posedge, so at negedge they show what the next edge will see.
  always @(negedge clock) begin
    logic drop;
    if (!reset_n) begin
      exp_q.delete();
      full_cnt        = 0;
      pmask           = '0;
      exp_ovf         = 1'b0;
      beat_pos        = 0;
      expect_vld_next = 1'b0;
      stall_cnt       = 0;
    end else begin
      chk("overflow", int'(bus.overflow), int'(exp_ovf));
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_valid", 1, 0);
        end else begin
          chk("beat_coef", int'($signed(bus.out_coef)), int'($signed(exp_q[0])));
          chk("beat_index", int'(bus.out_index), beat_pos);
          chk("beat_last", int'(bus.out_last), int'(beat_pos == 63));
        end
        stall_cnt = 0;
      end else begin
        if (expect_vld_next) chk("no_bubble", int'(bus.out_valid), 1);
        if (full_cnt > 0) begin
          stall_cnt++;
          if (stall_cnt > 2) begin
            chk("start_latency", stall_cnt, 2);
            stall_cnt = 0;
          end
        end
      end

      drop = bus.in_valid && (full_cnt == 2);
      expect_vld_next = 1'b0;
      if (bus.out_valid && bus.out_ready && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        beats_seen++;
        if (beat_pos == 63) begin
          beat_pos = 0;
          full_cnt--;
          expect_vld_next = (full_cnt > 0);
        end else begin
          beat_pos++;
          expect_vld_next = 1'b1;
        end
      end

      if (bus.in_valid) begin
        if (drop) begin
          exp_ovf = 1'b1;
        end else begin
          part[bus.in_tag]  = bus.in_coef;
          pmask[bus.in_tag] = 1'b1;
          if (&pmask) begin
            for (int k = 0; k < 64; k++) exp_q.push_back(part[zz_m[k]]);
            full_cnt++;
            pmask = '0;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input int tag, input int coef);
    bus.in_valid = 1'b1;
    bus.in_tag   = tag[5:0];
    bus.in_coef  = coef[CW-1:0];
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 3000; i++) begin
      if (exp_q.size() == 0 && full_cnt == 0 && !bus.out_valid) return;
      tick();
    end
    chk("drain_timeout", 0, 1);
  endtask

  task automatic wait_valid(input string name);
    for (int i = 0; i < 20; i++) begin
      if (bus.out_valid) break;
      tick();
    end
    chk(name, int'(bus.out_valid), 1);
  endtask

  initial begin
    int lit [6];
    int b0;
    lit = '{100, 101, 108, 116, 109, 102};
    build_zz();
    bus.in_valid  = 1'b0;
    bus.in_tag    = '0;
    bus.in_coef   = '0;
    bus.out_ready = 1'b0;

    chk("zz_model_k3", zz_m[3], 16);
    chk("zz_model_k60", zz_m[60], 47);

    // Reset state
    tick();
    tick();
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_out_index", int'(bus.out_index), 0);
    chk("rst_out_last", int'(bus.out_last), 0);
    chk("rst_out_coef", int'(bus.out_coef), 0);
    chk("rst_overflow", int'(bus.overflow), 0);
    reset_n = 1'b1;

    // Raster order, coef = tag+100
    bus.out_ready = 1'b1;
    for (int t = 0; t < 64; t++) send(t, t + 100);
    chk("lat_edge0", int'(bus.out_valid), 0);
    tick();
    chk("lat_edge1", int'(bus.out_valid), 0);
    tick();
    chk("lat_edge2", int'(bus.out_valid), 1);
    chk("fwd_k0", int'($signed(bus.out_coef)), lit[0]);
    for (int k = 1; k < 6; k++) begin
      tick();
      chk($sformatf("fwd_k%0d", k), int'($signed(bus.out_coef)), lit[k]);
    end
    for (int i = 0; i < 100; i++) begin
      if (bus.out_valid && bus.out_index == 6'd63) break;
      tick();
    end
    chk("fwd_idx63", int'(bus.out_index), 63);
    chk("fwd_last63", int'(bus.out_last), 1);
    wait_drain();

    // Reverse tag order gives the same stream
    for (int t = 63; t >= 0; t--) send(t, t + 100);
    wait_valid("rev_valid");
    chk("rev_k0", int'($signed(bus.out_coef)), 100);
    tick();
    chk("rev_k1", int'($signed(bus.out_coef)), 101);
    tick();
    chk("rev_k2", int'($signed(bus.out_coef)), 108);
    wait_drain();

    // Three blocks, one idle input cycle between them
    b0 = beats_seen;
    for (int b = 0; b < 3; b++) begin
      for (int t = 0; t < 64; t++) send(t, t * 7 + b * 300 - 900);
      if (b < 2) tick();
    end
    wait_drain();
    chk("three_blk_beats", beats_seen - b0, 192);
    chk("three_blk_ovf", int'(bus.overflow), 0);

    // Repeated tag 5: -3 then 7; raster 2 also 7
    send(5, -3);
    for (int t = 0; t < 64; t++) send(t, (t == 5 || t == 2) ? 7 : t + 200);
    wait_valid("dup_valid");
    chk("dup_k0", int'($signed(bus.out_coef)), 200);
    for (int i = 0; i < 5; i++) tick();
    chk("dup_idx5", int'(bus.out_index), 5);
    chk("dup_k5", int'($signed(bus.out_coef)), 7);
    for (int i = 0; i < 10; i++) tick();
    chk("dup_idx15", int'(bus.out_index), 15);
    chk("dup_k15_overwrite", int'($signed(bus.out_coef)), 7);
    wait_drain();

    // Consumer stalled: 129 entries, the last one dropped
    bus.out_ready = 1'b0;
    for (int t = 0; t < 64; t++) send(t, t + 100);
    for (int t = 0; t < 64; t++) send(t, t + 500);
    send(0, 999);
    chk("stall_ovf", int'(bus.overflow), 1);
    chk("stall_valid", int'(bus.out_valid), 1);
    chk("stall_idx", int'(bus.out_index), 0);
    chk("stall_coef", int'($signed(bus.out_coef)), 100);
    for (int i = 0; i < 3; i++) tick();
    chk("stall_hold_coef", int'($signed(bus.out_coef)), 100);
    for (int i = 0; i < 1000; i++) begin
      if (exp_q.size() == 0 && !bus.out_valid) break;
      bus.out_ready = (i % 3 != 0);
      tick();
    end
    bus.out_ready = 1'b1;
    wait_drain();
    chk("stall_ovf_sticky", int'(bus.overflow), 1);

    // Reset with one full block waiting and 40 entries of the next
    bus.out_ready = 1'b0;
    for (int t = 0; t < 64; t++) send(t, t + 100);
    for (int t = 0; t < 40; t++) send(t, t * 2);
    chk("prerst_valid", int'(bus.out_valid), 1);
    reset_n = 1'b0;
    #1;
    chk("midrst_valid", int'(bus.out_valid), 0);
    chk("midrst_coef", int'(bus.out_coef), 0);
    chk("midrst_ovf", int'(bus.overflow), 0);
    tick();
    tick();
    reset_n = 1'b1;
    bus.out_ready = 1'b1;
    for (int t = 0; t < 64; t++) send(t, 1000 - t * 30);
    wait_valid("postrst_valid");
    chk("postrst_k0", int'($signed(bus.out_coef)), 1000);
    tick();
    chk("postrst_k1", int'($signed(bus.out_coef)), 970);
    tick();
    chk("postrst_k2", int'($signed(bus.out_coef)), 760);
    wait_drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
